led_rate_scheduler: RTL

Time-shares the board's single blinking status LED among four requesters. Each requester asks for the LED with a 2-bit blink-rate code. The scheduler grants the LED round-robin for a fixed dwell time and drives the rate select and enable of the downstream clock-divider LED blinker. A blank gap separates consecutive grants so the operator can tell where one indication ends and the next begins.

---
 rtl/led_rate_scheduler.sv | 100 ++++++++++
 1 files changed

// File: rtl/led_rate_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : led_rate_scheduler
// Purpose  : Round-robin time-sharing of one status LED among four requesters,
//            with a blanked gap after every grant.
// Revision : 1.0
// ============================================================================
module led_rate_scheduler #(
    parameter int CNT_W        = 27,
    parameter int DWELL_CYCLES = 100_000_000,
    parameter int GAP_CYCLES   = 10_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [7:0] req_rate,
    output logic [1:0] rate_sel,
    output logic       led_en,
    output logic [3:0] grant,
    output logic       busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SHOW = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       last;
    logic [1:0]       winner;
    logic [1:0]       cand;

    // Scan downward from last+4 (== last) to last+1 so the nearest
    // requester after the previous winner overwrites all farther ones.
    always_comb begin
        winner = last + 2'd1;
        cand   = last;
        for (int k = 4; k >= 1; k--) begin
            cand = last + 2'(k);
            if (req[cand]) begin
                winner = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            last     <= 2'd3;
            grant    <= 4'b0000;
            rate_sel <= 2'b00;
            led_en   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        state    <= SHOW;
                        cnt      <= DWELL_LOAD;
                        last     <= winner;
                        grant    <= 4'b0001 << winner;
                        rate_sel <= req_rate[{winner, 1'b0} +: 2];
                        led_en   <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                SHOW: begin
                    if (cnt == '0 || !req[last]) begin
                        state  <= GAP;
                        cnt    <= GAP_LOAD;
                        grant  <= 4'b0000;
                        led_en <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    grant  <= 4'b0000;
                    led_en <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
